// File: rtl/sync_c1tx_fifo.sv
// Single-clock FIFO for CCI-P transmit paths: head status at T0, popped data registered at T2.
// Optional SYNC_FIFO_STICKY_ERR_EN turns overflow/underflow into sticky registered flags.
module sync_c1tx_fifo #(
    parameter int DATA_WIDTH  = 64,
    parameter int CTL_WIDTH   = 0,
    parameter int DEPTH_BASE2 = 3,
    parameter int GRAM_MODE   = 3,
    parameter int FULL_THRESH = 2
) (
    input  logic                                         Clk,
    input  logic                                         Resetb,
    input  logic [DATA_WIDTH-1:0]                        fifo_din,
    input  logic [((CTL_WIDTH > 0) ? CTL_WIDTH : 1)-1:0] fifo_ctlin,
    input  logic                                         fifo_wen,
    input  logic                                         fifo_rdack,
    output logic [DATA_WIDTH-1:0]                        T2_fifo_dout,
    output logic [((CTL_WIDTH > 0) ? CTL_WIDTH : 1)-1:0] T0_fifo_ctlout,
    output logic                                         T0_fifo_dout_v,
    output logic                                         T0_fifo_empty,
    output logic                                         T0_fifo_full,
    output logic [DEPTH_BASE2:0]                         T0_fifo_count,
    output logic                                         T0_fifo_almFull,
    output logic                                         T0_fifo_underflow,
    output logic                                         T0_fifo_overflow
);

    localparam int DEPTH = 1 << DEPTH_BASE2;
    localparam int CW    = (CTL_WIDTH > 0) ? CTL_WIDTH : 1;
    localparam logic [DEPTH_BASE2-1:0] PTR_ONE   = 1;
    localparam logic [DEPTH_BASE2:0]   CNT_ONE   = 1;
    localparam logic [DEPTH_BASE2:0]   CNT_FULL  = (DEPTH_BASE2+1)'(DEPTH);
    localparam logic [DEPTH_BASE2:0]   CNT_ALMF  = (DEPTH_BASE2+1)'(DEPTH - FULL_THRESH);

    // GRAM_MODE is only a storage hint; reject out-of-range settings at elaboration.
    if (GRAM_MODE < 0 || GRAM_MODE > 3) begin : g_bad_gram_mode
        $error("sync_c1tx_fifo: GRAM_MODE must be 0..3");
    end
    if (FULL_THRESH < 0 || FULL_THRESH >= DEPTH) begin : g_bad_full_thresh
        $error("sync_c1tx_fifo: FULL_THRESH must be 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0]  mem_data [DEPTH];
    logic [CW-1:0]          mem_ctl  [DEPTH];

    logic [DEPTH_BASE2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BASE2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BASE2:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0]  t1_dout_q;
    logic                   t1_vld_q;
    logic [DATA_WIDTH-1:0]  t2_dout_q;

    logic empty, full, do_pop, do_wr, ovf_req, udf_req;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_FULL);
        do_pop   = fifo_rdack && !empty;
        do_wr    = fifo_wen && (!full || do_pop);
        ovf_req  = fifo_wen && full && !fifo_rdack;
        udf_req  = fifo_rdack && empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr)  wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (do_wr && !do_pop)      count_d = count_q + CNT_ONE;
        else if (do_pop && !do_wr) count_d = count_q - CNT_ONE;
    end

    // Storage is intentionally not reset; count and pointers define validity.
    always_ff @(posedge Clk) begin
        if (do_wr) begin
            mem_data[wr_ptr_q] <= fifo_din;
            mem_ctl[wr_ptr_q]  <= fifo_ctlin;
        end
    end

    always_ff @(posedge Clk or posedge Resetb) begin
        if (Resetb) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            t1_vld_q  <= 1'b0;
            t1_dout_q <= '0;
            t2_dout_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            t1_vld_q <= do_pop;
            if (do_pop)   t1_dout_q <= mem_data[rd_ptr_q];
            if (t1_vld_q) t2_dout_q <= t1_dout_q;
        end
    end

`ifdef SYNC_FIFO_STICKY_ERR_EN
    logic ovf_q, udf_q;

    always_ff @(posedge Clk or posedge Resetb) begin
        if (Resetb) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | ovf_req;
            udf_q <= udf_q | udf_req;
        end
    end

    assign T0_fifo_overflow  = ovf_q;
    assign T0_fifo_underflow = udf_q;
`else
    assign T0_fifo_overflow  = ovf_req;
    assign T0_fifo_underflow = udf_req;
`endif

    assign T2_fifo_dout    = t2_dout_q;
    assign T0_fifo_ctlout  = (CTL_WIDTH > 0) ? mem_ctl[rd_ptr_q] : '0;
    assign T0_fifo_dout_v  = !empty;
    assign T0_fifo_empty   = empty;
    assign T0_fifo_full    = full;
    assign T0_fifo_count   = count_q;
    assign T0_fifo_almFull = (count_q >= CNT_ALMF);

endmodule

// File: tb/tb_sync_c1tx_fifo.sv
// Scoreboard bench for sync_c1tx_fifo: queue-based reference model, directed and random traffic.
module tb_sync_c1tx_fifo;
    localparam int DW    = 16;
    localparam int CW    = 4;
    localparam int DB2   = 2;
    localparam int FT    = 2;
    localparam int DEPTH = 1 << DB2;

    logic          Clk = 1'b0;
    logic          Resetb = 1'b1;
    logic [DW-1:0] fifo_din = '0;
    logic [CW-1:0] fifo_ctlin = '0;
    logic          fifo_wen = 1'b0;
    logic          fifo_rdack = 1'b0;
    logic [DW-1:0] T2_fifo_dout;
    logic [CW-1:0] T0_fifo_ctlout;
    logic          T0_fifo_dout_v, T0_fifo_empty, T0_fifo_full, T0_fifo_almFull;
    logic [DB2:0]  T0_fifo_count;
    logic          T0_fifo_underflow, T0_fifo_overflow;

    sync_c1tx_fifo #(
        .DATA_WIDTH(DW), .CTL_WIDTH(CW), .DEPTH_BASE2(DB2), .GRAM_MODE(3), .FULL_THRESH(FT)
    ) dut (
        .Clk(Clk), .Resetb(Resetb), .fifo_din(fifo_din), .fifo_ctlin(fifo_ctlin),
        .fifo_wen(fifo_wen), .fifo_rdack(fifo_rdack), .T2_fifo_dout(T2_fifo_dout),
        .T0_fifo_ctlout(T0_fifo_ctlout), .T0_fifo_dout_v(T0_fifo_dout_v),
        .T0_fifo_empty(T0_fifo_empty), .T0_fifo_full(T0_fifo_full),
        .T0_fifo_count(T0_fifo_count), .T0_fifo_almFull(T0_fifo_almFull),
        .T0_fifo_underflow(T0_fifo_underflow), .T0_fifo_overflow(T0_fifo_overflow)
    );

    always #5 Clk = ~Clk;

    typedef struct { logic [DW-1:0] d; logic [CW-1:0] c; } ent_t;
    typedef struct { logic [DW-1:0] d; int due; } pend_t;
    typedef struct {
        int count; bit empty; bit full; bit almf; bit dv; bit ovf; bit udf;
        bit has_ctl; logic [CW-1:0] ctl; logic [DW-1:0] t2;
    } exp_t;

    ent_t  mq[$];
    pend_t pq[$];
    exp_t  eq[$];
    logic [DW-1:0] t2m = '0;
    int cyc = 0;
    bit ovf_st = 1'b0, udf_st = 1'b0;
    int checks = 0, errors = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the expected status for this cycle goes to the scoreboard.
    task automatic drive(bit wen, bit rd, logic [DW-1:0] d, logic [CW-1:0] c);
        exp_t  e;
        pend_t p;
        ent_t  h;
        ent_t  n;
        bit    pop, wr, full, empty;
        @(posedge Clk);
        #1;
        fifo_wen = wen; fifo_rdack = rd; fifo_din = d; fifo_ctlin = c;
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            p = pq.pop_front();
            t2m = p.d;
        end
        empty = (mq.size() == 0);
        full  = (mq.size() == DEPTH);
        e.count = mq.size(); e.empty = empty; e.full = full;
        e.almf = (mq.size() >= DEPTH - FT); e.dv = !empty;
        e.has_ctl = !empty; e.ctl = empty ? '0 : mq[0].c; e.t2 = t2m;
`ifdef SYNC_FIFO_STICKY_ERR_EN
        e.ovf = ovf_st; e.udf = udf_st;
        ovf_st = ovf_st | (wen && full && !rd);
        udf_st = udf_st | (rd && empty);
`else
        e.ovf = wen && full && !rd;
        e.udf = rd && empty;
`endif
        eq.push_back(e);
        pop = rd && !empty;
        wr  = wen && (!full || pop);
        if (pop) begin
            h = mq.pop_front();
            p.d = h.d; p.due = cyc + 2;
            pq.push_back(p);
        end
        if (wr) begin
            n.d = d; n.c = c;
            mq.push_back(n);
        end
        cyc++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic reset_async();
        @(posedge Clk);
        #1;
        fifo_wen = 1'b0; fifo_rdack = 1'b0;
        Resetb = 1'b1;
        #2;
        Resetb = 1'b0;
        mq.delete(); pq.delete();
        t2m = '0; ovf_st = 1'b0; udf_st = 1'b0;
    endtask

    // Monitor: reset-state checks while reset is high, scoreboard compare otherwise.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk or posedge Resetb);
            if (Resetb) begin
                #1;
                chk("rst_count", 64'(T0_fifo_count), 64'd0);
                chk("rst_t2", 64'(T2_fifo_dout), 64'd0);
                chk("rst_empty", 64'(T0_fifo_empty), 64'd1);
                chk("rst_dout_v", 64'(T0_fifo_dout_v), 64'd0);
                chk("rst_full", 64'(T0_fifo_full), 64'd0);
                chk("rst_almfull", 64'(T0_fifo_almFull), 64'd0);
                chk("rst_ovf", 64'(T0_fifo_overflow), 64'd0);
                chk("rst_udf", 64'(T0_fifo_underflow), 64'd0);
            end else if (eq.size() > 0) begin
                e = eq.pop_front();
                chk("count", 64'(T0_fifo_count), 64'(e.count));
                chk("empty", 64'(T0_fifo_empty), 64'(e.empty));
                chk("full", 64'(T0_fifo_full), 64'(e.full));
                chk("almfull", 64'(T0_fifo_almFull), 64'(e.almf));
                chk("dout_v", 64'(T0_fifo_dout_v), 64'(e.dv));
                chk("overflow", 64'(T0_fifo_overflow), 64'(e.ovf));
                chk("underflow", 64'(T0_fifo_underflow), 64'(e.udf));
                chk("t2_dout", 64'(T2_fifo_dout), 64'(e.t2));
                if (e.has_ctl) chk("ctlout", 64'(T0_fifo_ctlout), 64'(e.ctl));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        Resetb = 1'b0;
        idle(2);
        // two words, popped as soon as the head is valid
        drive(1'b1, 1'b0, 16'h00A1, 4'h1);
        drive(1'b1, 1'b1, 16'h00A2, 4'h2);
        drive(1'b0, 1'b1, '0, '0);
        idle(4);
        // fill to full, then one overflowing write
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 16'h00B0 + 16'(i), 4'(i));
        drive(1'b1, 1'b0, 16'h00BF, 4'hF);
        idle(1);
        // write+pop at full, then drain with pointer wrap and one underflow
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 16'h00C0 + 16'(i), 4'(i + 8));
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, '0, '0);
        idle(3);
        drive(1'b0, 1'b1, '0, '0);
        idle(2);
        // async reset with entries queued
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 16'h00E0 + 16'(i), 4'(i));
        reset_async();
        drive(1'b1, 1'b0, 16'h00D5, 4'h5);
        drive(1'b0, 1'b1, '0, '0);
        idle(3);
        // random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) reset_async();
            drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45,
                  DW'($urandom), CW'($urandom));
        end
        idle(4);
        @(negedge Clk);
        #1;
        if (eq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", eq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
